// File: rtl/rv_exit_monitor.sv
// rtl/rv_exit_monitor.sv - multi-hart end-of-program monitor: exit capture, ecall counts, watchdog, drain/done
module rv_exit_monitor #(
    parameter int NHART     = 1,
    parameter int EXIT_CODE = 93,
    parameter int DRAIN_CYC = 5,
    parameter int CW        = 32,
    parameter int ECW       = 16
) (
    input  logic                  cclk,
    input  logic                  reset,
    input  logic [NHART-1:0]      ir_valid,
    input  logic [32*NHART-1:0]   ir,
    input  logic [32*NHART-1:0]   sysno,
    input  logic [32*NHART-1:0]   arg0,
    input  logic [CW-1:0]         timeout_lim,
    output logic [NHART-1:0]      exited,
    output logic [32*NHART-1:0]   exit_code,
    output logic [ECW*NHART-1:0]  ecall_cnt,
    output logic [CW-1:0]         cycles,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  fail
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYC);

    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
    localparam logic [31:0] EXIT_NUM   = 32'(EXIT_CODE);

    logic [1:0]    r_state;
    logic [DW-1:0] r_drain;
    logic [CW-1:0] r_cycles;
    logic          r_timeout;
    logic          w_in_run;
    logic          w_all_exited;
    logic          w_wdog_hit;

    assign w_in_run = (r_state == S_RUN);

    genvar g;
    generate
        for (g = 0; g < NHART; g++) begin : g_hart
            logic           r_ex;
            logic [31:0]    r_code;
            logic [ECW-1:0] r_cnt;
            logic           w_ecall;
            logic           w_is_exit;

            assign w_ecall   = ir_valid[g] && (ir[32*g +: 32] == ECALL_WORD);
            assign w_is_exit = (sysno[32*g +: 32] == EXIT_NUM);

            // Once a hart has exited, or the monitor has left RUN, its ecalls are ignored.
            always_ff @(posedge cclk or posedge reset) begin
                if (reset) begin
                    r_ex   <= 1'b0;
                    r_code <= 32'd0;
                    r_cnt  <= '0;
                end else if (w_in_run && !r_ex && w_ecall) begin
                    if (w_is_exit) begin
                        r_ex   <= 1'b1;
                        r_code <= arg0[32*g +: 32];
                    end else if (r_cnt != {ECW{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign exited[g]              = r_ex;
            assign exit_code[32*g +: 32]  = r_code;
            assign ecall_cnt[ECW*g +: ECW] = r_cnt;
        end
    endgenerate

    assign w_all_exited = &exited;
    assign w_wdog_hit   = (timeout_lim != '0) && (r_cycles >= timeout_lim);

    // Exit has priority over the watchdog; cycles hold on the edge that leaves RUN.
    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_drain   <= '0;
            r_cycles  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_all_exited) begin
                        r_state <= S_DRAIN;
                        r_drain <= DRAIN_INIT;
                    end else if (w_wdog_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_DRAIN;
                        r_drain   <= DRAIN_INIT;
                    end else if (r_cycles != {CW{1'b1}}) begin
                        r_cycles <= r_cycles + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: r_state <= S_DONE;
            endcase
        end
    end

    assign cycles  = r_cycles;
    assign busy    = w_in_run;
    assign done    = (r_state == S_DONE);
    assign timeout = r_timeout;
    assign fail    = done && (r_timeout || (|exit_code));

endmodule

// File: tb/tb_rv_exit_monitor.sv
// tb/tb_rv_exit_monitor.sv - directed self-checking bench for rv_exit_monitor
module tb_rv_exit_monitor;

    localparam int NH  = 2;
    localparam int ECW = 3;

    logic            cclk = 1'b0;
    logic            reset = 1'b1;
    logic [NH-1:0]   ir_valid;
    logic [32*NH-1:0] ir;
    logic [32*NH-1:0] sysno;
    logic [32*NH-1:0] arg0;
    logic [31:0]     timeout_lim;
    logic [NH-1:0]   exited;
    logic [32*NH-1:0] exit_code;
    logic [ECW*NH-1:0] ecall_cnt;
    logic [31:0]     cycles;
    logic            busy;
    logic            done;
    logic            timeout;
    logic            fail;

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;

    rv_exit_monitor #(
        .NHART(NH), .EXIT_CODE(93), .DRAIN_CYC(5), .CW(32), .ECW(ECW)
    ) dut (
        .cclk(cclk), .reset(reset), .ir_valid(ir_valid), .ir(ir), .sysno(sysno),
        .arg0(arg0), .timeout_lim(timeout_lim), .exited(exited), .exit_code(exit_code),
        .ecall_cnt(ecall_cnt), .cycles(cycles), .busy(busy), .done(done),
        .timeout(timeout), .fail(fail)
    );

    always #5 cclk = ~cclk;

    task automatic clear_in();
        ir_valid = '0;
        ir       = '0;
        sysno    = '0;
        arg0     = '0;
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic set_hart(input int h, input logic [31:0] w, input logic [31:0] a7, input logic [31:0] a0);
        ir_valid[h]       = 1'b1;
        ir[32*h +: 32]    = w;
        sysno[32*h +: 32] = a7;
        arg0[32*h +: 32]  = a0;
    endtask

    task automatic retire_at(input int k, input int h, input logic [31:0] w, input logic [31:0] a7, input logic [31:0] a0);
        run_to(k - 1);
        set_hart(h, w, a7, a0);
        tick();
        clear_in();
    endtask

    task automatic do_reset(input logic [31:0] lim);
        reset = 1'b1;
        clear_in();
        timeout_lim = lim;
        @(negedge cclk);
        @(negedge cclk);
        reset = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        do_reset(32'd0);
        n_total++; if (exited !== 2'b00) $display("FAIL rst_exited got %b exp 00", exited); else n_pass++;
        n_total++; if (exit_code !== 64'd0) $display("FAIL rst_code got %h exp 0", exit_code); else n_pass++;
        n_total++; if (ecall_cnt !== 6'd0) $display("FAIL rst_cnt got %h exp 0", ecall_cnt); else n_pass++;
        n_total++; if (cycles !== 32'd0) $display("FAIL rst_cycles got %0d exp 0", cycles); else n_pass++;
        n_total++; if ({busy, done, timeout, fail} !== 4'b1000) $display("FAIL rst_flags got %b exp 1000", {busy, done, timeout, fail}); else n_pass++;
        tick();
        n_total++; if (cycles !== 32'd1) $display("FAIL rst_cycles1 got %0d exp 1", cycles); else n_pass++;
    endtask

    task automatic test_single_exit();
        do_reset(32'd0);
        retire_at(5, 1, 32'h73, 32'd93, 32'd0);
        retire_at(10, 0, 32'h73, 32'd93, 32'd0);
        n_total++; if (exited !== 2'b11) $display("FAIL t1_exited got %b exp 11", exited); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL t1_busy10 got %b exp 1", busy); else n_pass++;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL t1_busy11 got %b exp 0", busy); else n_pass++;
        run_to(16);
        n_total++; if (done !== 1'b0) $display("FAIL t1_done16 got %b exp 0", done); else n_pass++;
        tick();
        n_total++; if (done !== 1'b1) $display("FAIL t1_done17 got %b exp 1", done); else n_pass++;
        n_total++; if (fail !== 1'b0) $display("FAIL t1_fail got %b exp 0", fail); else n_pass++;
        n_total++; if (cycles !== 32'd10) $display("FAIL t1_cycles got %0d exp 10", cycles); else n_pass++;
    endtask

    task automatic test_two_harts();
        do_reset(32'd0);
        retire_at(20, 0, 32'h73, 32'd93, 32'd0);
        retire_at(40, 1, 32'h73, 32'd93, 32'd3);
        run_to(46);
        n_total++; if (done !== 1'b0) $display("FAIL t2_done46 got %b exp 0", done); else n_pass++;
        tick();
        n_total++; if (done !== 1'b1) $display("FAIL t2_done47 got %b exp 1", done); else n_pass++;
        n_total++; if (exit_code !== {32'd3, 32'd0}) $display("FAIL t2_code got %h exp 0000000300000000", exit_code); else n_pass++;
        n_total++; if ({timeout, fail} !== 2'b01) $display("FAIL t2_tofail got %b exp 01", {timeout, fail}); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset(32'd100);
        run_to(100);
        n_total++; if ({busy, timeout} !== 2'b10) $display("FAIL t3_e100 got %b exp 10", {busy, timeout}); else n_pass++;
        tick();
        n_total++; if ({busy, timeout} !== 2'b01) $display("FAIL t3_e101 got %b exp 01", {busy, timeout}); else n_pass++;
        run_to(106);
        n_total++; if (done !== 1'b0) $display("FAIL t3_done106 got %b exp 0", done); else n_pass++;
        tick();
        n_total++; if ({done, fail} !== 2'b11) $display("FAIL t3_donefail got %b exp 11", {done, fail}); else n_pass++;
        n_total++; if (cycles !== 32'd100) $display("FAIL t3_cycles got %0d exp 100", cycles); else n_pass++;
    endtask

    task automatic test_exit_beats_timeout();
        do_reset(32'd20);
        retire_at(10, 0, 32'h73, 32'd93, 32'd0);
        retire_at(20, 1, 32'h73, 32'd93, 32'd0);
        tick();
        n_total++; if ({busy, timeout} !== 2'b00) $display("FAIL tb_e21 got %b exp 00", {busy, timeout}); else n_pass++;
        run_to(27);
        n_total++; if ({done, fail, timeout} !== 3'b100) $display("FAIL tb_done got %b exp 100", {done, fail, timeout}); else n_pass++;
    endtask

    task automatic test_ecall_count();
        do_reset(32'd0);
        for (int k = 1; k <= 3; k++) retire_at(k, 0, 32'h73, 32'd64, 32'd1);
        retire_at(4, 0, 32'h73, 32'd93, 32'd0);
        retire_at(5, 0, 32'h73, 32'd93, 32'd7);
        retire_at(6, 0, 32'h73, 32'd64, 32'd0);
        retire_at(7, 1, 32'h0010_0073, 32'd93, 32'd4);
        run_to(7);
        ir[63:32] = 32'h73; sysno[63:32] = 32'd93; arg0[63:32] = 32'd5;
        tick();
        clear_in();
        n_total++; if (exited !== 2'b01) $display("FAIL t4_exited got %b exp 01", exited); else n_pass++;
        n_total++; if (ecall_cnt[2:0] !== 3'd3) $display("FAIL t4_cnt0 got %0d exp 3", ecall_cnt[2:0]); else n_pass++;
        n_total++; if (exit_code[31:0] !== 32'd0) $display("FAIL t4_code0 got %h exp 0", exit_code[31:0]); else n_pass++;
        n_total++; if (ecall_cnt[5:3] !== 3'd0) $display("FAIL t4_cnt1 got %0d exp 0", ecall_cnt[5:3]); else n_pass++;
        for (int k = 9; k <= 14; k++) retire_at(k, 1, 32'h73, 32'd1, 32'd0);
        n_total++; if (ecall_cnt[5:3] !== 3'd6) $display("FAIL t4_cnt1_6 got %0d exp 6", ecall_cnt[5:3]); else n_pass++;
        for (int k = 15; k <= 17; k++) retire_at(k, 1, 32'h73, 32'd1, 32'd0);
        n_total++; if (ecall_cnt[5:3] !== 3'd7) $display("FAIL t4_sat got %0d exp 7", ecall_cnt[5:3]); else n_pass++;
        n_total++; if ({exited, busy} !== 3'b011) $display("FAIL t4_state got %b exp 011", {exited, busy}); else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset(32'd0);
        run_to(2);
        set_hart(0, 32'h73, 32'd93, 32'd5);
        set_hart(1, 32'h73, 32'd93, 32'd9);
        tick();
        clear_in();
        n_total++; if (exited !== 2'b11) $display("FAIL t5_exited got %b exp 11", exited); else n_pass++;
        n_total++; if (exit_code !== {32'd9, 32'd5}) $display("FAIL t5_code got %h exp 0000000900000005", exit_code); else n_pass++;
        run_to(9);
        n_total++; if (done !== 1'b0) $display("FAIL t5_done9 got %b exp 0", done); else n_pass++;
        tick();
        n_total++; if ({done, fail} !== 2'b11) $display("FAIL t5_donefail got %b exp 11", {done, fail}); else n_pass++;
        retire_at(11, 0, 32'h73, 32'd64, 32'd0);
        run_to(13);
        n_total++; if ({ecall_cnt, cycles} !== {6'd0, 32'd3}) $display("FAIL t5_hold got %h/%0d exp 0/3", ecall_cnt, cycles); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL t5_sticky got %b exp 1", done); else n_pass++;
    endtask

    task automatic test_reset_in_drain();
        do_reset(32'd0);
        run_to(2);
        set_hart(0, 32'h73, 32'd93, 32'd1);
        set_hart(1, 32'h73, 32'd93, 32'd1);
        tick();
        clear_in();
        run_to(6);
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL t6_drain got %b exp 00", {busy, done}); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if ({exited, exit_code, ecall_cnt, cycles} !== 104'd0) $display("FAIL t6_async got %h exp 0", {exited, exit_code, ecall_cnt, cycles}); else n_pass++;
        n_total++; if ({busy, done, timeout, fail} !== 4'b1000) $display("FAIL t6_flags got %b exp 1000", {busy, done, timeout, fail}); else n_pass++;
        do_reset(32'd0);
        run_to(1);
        set_hart(0, 32'h73, 32'd93, 32'd0);
        set_hart(1, 32'h73, 32'd93, 32'd0);
        tick();
        clear_in();
        run_to(8);
        n_total++; if (done !== 1'b0) $display("FAIL t6_done8 got %b exp 0", done); else n_pass++;
        tick();
        n_total++; if ({done, fail, cycles} !== {2'b10, 32'd2}) $display("FAIL t6_final got %b/%0d exp 10/2", {done, fail}, cycles); else n_pass++;
    endtask

    initial begin
        clear_in();
        timeout_lim = '0;
        test_reset();
        test_single_exit();
        test_two_harts();
        test_timeout();
        test_exit_beats_timeout();
        test_ecall_count();
        test_simultaneous();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
